shift_reg_universal: RTL and testbench



---
 rtl/shift_reg_universal.sv | 118 +++++++++++
 tb/tb_shift_reg_universal.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_universal.sv
// Parametrised universal shift register with multi-bit steps, rotate and arithmetic modes,
// parallel load, and a self-timed burst that shifts the whole word out under busy/done.
module shift_reg_universal #(
  parameter int N    = 8,
  parameter int STEP = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            load,
  input  logic [N-1:0]    data,
  input  logic [2:0]      mode,
  input  logic [STEP-1:0] ser_in,
  input  logic            start,
  output logic [N-1:0]    q,
  output logic [STEP-1:0] ser_out,
  output logic            busy,
  output logic            done
);

  localparam int SHIFTS = (N + STEP - 1) / STEP;
  localparam int CW     = $clog2(SHIFTS + 1);

  localparam logic [CW-1:0] SHIFTS_CNT = CW'(SHIFTS);
  localparam logic [CW-1:0] ONE_CNT    = CW'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_ROR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ASR  = 3'b101;

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic [2:0]    latched_mode;
  logic [2:0]    active_mode;
  logic [N-1:0]  shifted;
  logic          start_ok;

  // While a burst runs, the mode captured at start governs both shifting and ser_out.
  assign active_mode = (state == RUN) ? latched_mode : mode;
  assign start_ok    = (mode >= M_SHR) && (mode <= M_ASR);

  always_comb begin
    shifted = q;
    case (active_mode)
      M_SHR:   shifted = {ser_in, q[N-1:STEP]};
      M_SHL:   shifted = {q[N-1-STEP:0], ser_in};
      M_ROR:   shifted = {q[STEP-1:0], q[N-1:STEP]};
      M_ROL:   shifted = {q[N-1-STEP:0], q[N-1:N-STEP]};
      M_ASR:   shifted = {{STEP{q[N-1]}}, q[N-1:STEP]};
      default: shifted = q;
    endcase
  end

  always_comb begin
    ser_out = '0;
    case (active_mode)
      M_SHR, M_ROR, M_ASR: ser_out = q[STEP-1:0];
      M_SHL, M_ROL:        ser_out = q[N-1:N-STEP];
      default:             ser_out = '0;
    endcase
  end

  // DONE lasts one cycle and otherwise behaves like IDLE, so bursts can run back to back.
  always_ff @(posedge clock) begin
    if (reset) begin
      q            <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      state        <= IDLE;
      count        <= '0;
      latched_mode <= M_HOLD;
    end else begin
      done <= 1'b0;
      if (enable) begin
        case (state)
          RUN: begin
            if (load) begin
              q     <= data;
              busy  <= 1'b0;
              count <= '0;
              state <= IDLE;
            end else begin
              q     <= shifted;
              count <= count - ONE_CNT;
              if (count == ONE_CNT) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end
            end
          end
          default: begin
            if (load) begin
              q     <= data;
              state <= IDLE;
            end else if (start && start_ok) begin
              latched_mode <= mode;
              count        <= SHIFTS_CNT;
              busy         <= 1'b1;
              state        <= RUN;
            end else begin
              q     <= shifted;
              state <= IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shift_reg_universal.sv
// Bench for shift_reg_universal: directed scenarios plus random traffic on STEP=1 and STEP=3
// instances, each compared against an arithmetic reference model every cycle.
module tb_shift_reg_universal;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic       en1, ld1, st1;
  logic [7:0] d1;
  logic [2:0] md1;
  logic [0:0] si1;
  logic [7:0] q1;
  logic [0:0] so1;
  logic       busy1, done1;

  logic       en3, ld3, st3;
  logic [7:0] d3;
  logic [2:0] md3;
  logic [2:0] si3;
  logic [7:0] q3;
  logic [2:0] so3;
  logic       busy3, done3;

  shift_reg_universal #(.N(8), .STEP(1)) u1 (
    .clock(clock), .reset(reset), .enable(en1), .load(ld1), .data(d1), .mode(md1),
    .ser_in(si1), .start(st1), .q(q1), .ser_out(so1), .busy(busy1), .done(done1)
  );

  shift_reg_universal #(.N(8), .STEP(3)) u3 (
    .clock(clock), .reset(reset), .enable(en3), .load(ld3), .data(d3), .mode(md3),
    .ser_in(si3), .start(st3), .q(q3), .ser_out(so3), .busy(busy3), .done(done3)
  );

  int checks = 0;
  int failures = 0;
  bit checking = 0;

  int mq[2];
  int mrem[2];
  int mlm[2];
  bit mbusy[2];
  bit mdone[2];

  logic [7:0] expShr[3] = '{8'hD2, 8'hE9, 8'hF4};
  logic [7:0] serPat = 8'b1000_0001;
  int busyCount;

  function automatic int stepOf(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int shiftModel(int v, int m, int si, int s);
    case (m)
      1:       return ((v >> s) | (si << (8 - s))) & 255;
      2:       return ((v << s) | si) & 255;
      3:       return ((v >> s) | (v << (8 - s))) & 255;
      4:       return ((v << s) | (v >> (8 - s))) & 255;
      5:       return (v >= 128) ? (((v >> s) | (255 << (8 - s))) & 255) : (v >> s);
      default: return v;
    endcase
  endfunction

  function automatic int serModel(int v, int m, int s);
    case (m)
      1, 3, 5: return v & ((1 << s) - 1);
      2, 4:    return v >> (8 - s);
      default: return 0;
    endcase
  endfunction

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelStep(int k, bit en, bit ld, int d, int md, int si, bit st);
    int shifts;
    shifts = (8 + stepOf(k) - 1) / stepOf(k);
    if (reset) begin
      mq[k] = 0; mbusy[k] = 0; mdone[k] = 0; mrem[k] = 0;
    end else begin
      mdone[k] = 0;
      if (en) begin
        if (mbusy[k]) begin
          if (ld) begin
            mq[k] = d; mbusy[k] = 0;
          end else begin
            mq[k] = shiftModel(mq[k], mlm[k], si, stepOf(k));
            mrem[k]--;
            if (mrem[k] == 0) begin
              mbusy[k] = 0; mdone[k] = 1;
            end
          end
        end else if (ld) begin
          mq[k] = d;
        end else if (st && md >= 1 && md <= 5) begin
          mlm[k] = md; mrem[k] = shifts; mbusy[k] = 1;
        end else begin
          mq[k] = shiftModel(mq[k], md, si, stepOf(k));
        end
      end
    end
  endtask

  // Compare both instances mid-cycle, then let the prepared inputs take effect on one edge.
  task automatic applyStimulus();
    int am;
    @(negedge clock);
    if (checking) begin
      checkOutput("m1_q", q1, mq[0]);
      checkOutput("m1_busy", busy1, mbusy[0]);
      checkOutput("m1_done", done1, mdone[0]);
      am = mbusy[0] ? mlm[0] : int'(md1);
      if (am != 0) checkOutput("m1_ser", so1, serModel(mq[0], am, 1));
      checkOutput("m3_q", q3, mq[1]);
      checkOutput("m3_busy", busy3, mbusy[1]);
      checkOutput("m3_done", done3, mdone[1]);
      am = mbusy[1] ? mlm[1] : int'(md3);
      if (am != 0) checkOutput("m3_ser", so3, serModel(mq[1], am, 3));
    end
    @(posedge clock);
    modelStep(0, en1, ld1, d1, md1, si1, st1);
    modelStep(1, en3, ld3, d3, md3, si3, st3);
    if (reset) checking = 1;
    #1;
  endtask

  initial begin
    reset = 1;
    en1 = 0; ld1 = 0; st1 = 0; d1 = 0; md1 = 0; si1 = 0;
    en3 = 0; ld3 = 0; st3 = 0; d3 = 0; md3 = 0; si3 = 0;
    for (int k = 0; k < 2; k++) begin
      mq[k] = 0; mrem[k] = 0; mlm[k] = 0; mbusy[k] = 0; mdone[k] = 0;
    end
    applyStimulus();
    applyStimulus();
    reset = 0;

    // Reset must win even with enable low.
    en1 = 1; ld1 = 1; d1 = 8'hFF; en3 = 1; ld3 = 1; d3 = 8'hFF;
    applyStimulus();
    checkOutput("load_ff", q1, 8'hFF);
    en1 = 0; ld1 = 0; en3 = 0; ld3 = 0; reset = 1;
    applyStimulus();
    reset = 0;
    checkOutput("rst_q", q1, 8'h00);
    checkOutput("rst_busy", busy1, 1'b0);
    checkOutput("rst_done", done1, 1'b0);
    checkOutput("rst_q3", q3, 8'h00);

    en1 = 1; ld1 = 1; d1 = 8'hA5;
    applyStimulus();
    ld1 = 0; md1 = 3'b001; si1 = 1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("shr_q", q1, expShr[i]);
    end

    md1 = 0; ld1 = 1; d1 = 8'h80;
    applyStimulus();
    ld1 = 0; md1 = 3'b101;
    applyStimulus();
    checkOutput("asr_c0", q1, 8'hC0);
    applyStimulus();
    checkOutput("asr_e0", q1, 8'hE0);
    md1 = 0; ld1 = 1; d1 = 8'h40;
    applyStimulus();
    ld1 = 0; md1 = 3'b101;
    applyStimulus();
    checkOutput("asr_20", q1, 8'h20);

    md1 = 0; ld1 = 1; d1 = 8'h81;
    applyStimulus();
    ld1 = 0; st1 = 1; md1 = 3'b011;
    applyStimulus();
    st1 = 0; md1 = 0;
    checkOutput("rot_busy_start", busy1, 1'b1);
    busyCount = 0;
    for (int i = 0; i < 8; i++) begin
      si1 = 1'($urandom);
      checkOutput("rot_ser", so1, serPat[i]);
      if (busy1) busyCount++;
      applyStimulus();
    end
    checkOutput("rot_q", q1, 8'h81);
    checkOutput("rot_busy_end", busy1, 1'b0);
    checkOutput("rot_done", done1, 1'b1);
    checkOutput("rot_busy_cycles", busyCount, 8);
    applyStimulus();
    checkOutput("rot_done_clear", done1, 1'b0);

    en1 = 0;
    en3 = 1; ld3 = 1; d3 = 8'h01;
    applyStimulus();
    ld3 = 0; st3 = 1; md3 = 3'b100;
    applyStimulus();
    st3 = 0; md3 = 0;
    busyCount = busy3 ? 1 : 0;
    applyStimulus();
    checkOutput("rol3_08", q3, 8'h08);
    if (busy3) busyCount++;
    en3 = 0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      checkOutput("stall_q", q3, 8'h08);
      checkOutput("stall_busy", busy3, 1'b1);
      if (busy3) busyCount++;
    end
    en3 = 1;
    applyStimulus();
    checkOutput("rol3_40", q3, 8'h40);
    if (busy3) busyCount++;
    applyStimulus();
    checkOutput("rol3_02", q3, 8'h02);
    checkOutput("rol3_done", done3, 1'b1);
    checkOutput("rol3_busy_end", busy3, 1'b0);
    checkOutput("rol3_busy_cycles", busyCount, 5);
    applyStimulus();
    checkOutput("rol3_done_clear", done3, 1'b0);
    en3 = 0;

    en1 = 1; ld1 = 1; d1 = 8'h5A; md1 = 0;
    applyStimulus();
    ld1 = 0; st1 = 1; md1 = 3'b001; si1 = 0;
    applyStimulus();
    st1 = 0;
    applyStimulus();
    applyStimulus();
    ld1 = 1; d1 = 8'h3C;
    applyStimulus();
    checkOutput("abort_q", q1, 8'h3C);
    checkOutput("abort_busy", busy1, 1'b0);
    ld1 = 0; md1 = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      checkOutput("abort_no_done", done1, 1'b0);
    end

    ld1 = 1; d1 = 8'h5A;
    applyStimulus();
    ld1 = 0; st1 = 1; md1 = 3'b001;
    applyStimulus();
    st1 = 0;
    applyStimulus();
    applyStimulus();
    reset = 1;
    applyStimulus();
    reset = 0; md1 = 0;
    checkOutput("rabort_q", q1, 8'h00);
    checkOutput("rabort_busy", busy1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      checkOutput("rabort_no_done", done1, 1'b0);
    end

    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      en1 = ($urandom_range(0, 7) != 0);
      ld1 = ($urandom_range(0, 15) == 0);
      st1 = ($urandom_range(0, 3) == 0);
      d1 = 8'($urandom); md1 = 3'($urandom); si1 = 1'($urandom);
      en3 = ($urandom_range(0, 7) != 0);
      ld3 = ($urandom_range(0, 15) == 0);
      st3 = ($urandom_range(0, 3) == 0);
      d3 = 8'($urandom); md3 = 3'($urandom); si3 = 3'($urandom);
      applyStimulus();
    end
    reset = 0; en1 = 0; en3 = 0;
    applyStimulus();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
